// File: rtl/pwm_ramp_ctrl_if.sv
// Command/status bundle between the SPI receive stage and the PWM ramp controller.
interface pwm_ramp_ctrl_if;
    logic [7:0] control_value;
    logic       enable;
    logic       pwm_out;
    logic [7:0] duty_cur;
    logic       at_target;

    modport master (
        output control_value,
        output enable,
        input  pwm_out,
        input  duty_cur,
        input  at_target
    );

    modport slave (
        input  control_value,
        input  enable,
        output pwm_out,
        output duty_cur,
        output at_target
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Slew-limited PWM driver: duty walks toward the SPI command at STEP per RAMP_DIV cycles,
// and the comparator only sees a new duty at the 256-cycle period boundary.
module pwm_ramp_ctrl #(
    parameter int RAMP_DIV = 1024,
    parameter int STEP     = 1
) (
    input  logic            clk,
    input  logic            rst,
    pwm_ramp_ctrl_if.slave  bus
);

    localparam int            PW        = $clog2(RAMP_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    typedef enum logic [1:0] {HOLD, UP, DOWN} state_t;

    logic [7:0]    r_target;
    logic [7:0]    r_duty;
    logic [7:0]    r_shadow;
    logic [7:0]    r_pwm_cnt;
    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic          r_pwm;
    logic          r_at;

    logic          w_tick;
    logic [7:0]    w_duty_nxt;
    state_t        w_state_nxt;

    // One step toward tgt, clamped so the result lands on tgt instead of passing it.
    function automatic logic [7:0] slew(input state_t st, input logic [7:0] tgt,
                                        input logic [7:0] cur);
        logic [8:0] diff;
        logic [8:0] mag;
        logic [8:0] res;
        diff = 9'd0;
        mag  = 9'd0;
        res  = {1'b0, cur};
        case (st)
            UP: begin
                diff = {1'b0, tgt} - {1'b0, cur};
                mag  = (diff < STEP9) ? diff : STEP9;
                res  = {1'b0, cur} + mag;
            end
            DOWN: begin
                diff = {1'b0, cur} - {1'b0, tgt};
                mag  = (diff < STEP9) ? diff : STEP9;
                res  = {1'b0, cur} - mag;
            end
            default: res = {1'b0, cur};
        endcase
        return res[7:0];
    endfunction

    function automatic state_t classify(input logic [7:0] tgt, input logic [7:0] cur);
        if (tgt > cur)
            return UP;
        else if (tgt < cur)
            return DOWN;
        else
            return HOLD;
    endfunction

    assign w_tick      = bus.enable && (r_presc == PRESC_MAX);
    assign w_duty_nxt  = w_tick ? slew(r_state, r_target, r_duty) : r_duty;
    // State looks ahead at the values target and duty will hold after this edge.
    assign w_state_nxt = classify(bus.control_value, w_duty_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target  <= 8'd0;
            r_duty    <= 8'd0;
            r_shadow  <= 8'd0;
            r_pwm_cnt <= 8'd0;
            r_presc   <= '0;
            r_state   <= HOLD;
            r_pwm     <= 1'b0;
            r_at      <= 1'b1;
        end else begin
            r_target <= bus.control_value;
            if (bus.enable) begin
                r_presc   <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                r_duty    <= w_duty_nxt;
                r_state   <= w_state_nxt;
                r_at      <= (w_state_nxt == HOLD);
            end else begin
                r_presc   <= '0;
                r_pwm_cnt <= 8'd0;
            end
            // Shadow reload at the period boundary keeps each PWM period glitch-free.
            if (r_pwm_cnt == 8'hFF)
                r_shadow <= r_duty;
            r_pwm <= bus.enable && (r_pwm_cnt < r_shadow);
        end
    end

    assign bus.pwm_out   = r_pwm;
    assign bus.duty_cur  = r_duty;
    assign bus.at_target = r_at;

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Consumes the 8-bit control_value produced by the SPI receive stage and drives a single PWM output.
- Duty cycle slews toward the commanded value at a programmable rate, so abrupt SPI updates never produce step changes at the actuator.
- Runs on the same clock as the SPI receive stage; the command needs no synchroniser.

Parameters:
- RAMP_DIV, 1024: clock cycles between successive ramp steps (>=2).
- STEP, 1: maximum duty change per ramp step (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- control_value  input  8  commanded duty (0..255), level input, may change on any cycle.
- enable  input  1  1 = ramp and PWM run; 0 = output forced low, ramp frozen.
- pwm_out  output  1  PWM waveform, period 256 clk.
- duty_cur  output  8  current (ramped) duty value.
- at_target  output  1  1 when duty_cur == registered target.

Behaviour:
- Reset (async, rst high): target=0, duty_cur=0, duty_shadow=0, pwm_cnt=0, prescaler=0, state=HOLD, pwm_out=0, at_target=1.
- Target capture:
  - target <= control_value every cycle; one cycle of latency from control_value to target.
- Prescaler:
  - When enable=1, counts 0..RAMP_DIV-1 and wraps.
  - tick is asserted on the cycle the prescaler equals RAMP_DIV-1.
  - When enable=0, the prescaler is held at 0.
- States:
  - HOLD: duty_cur == target.
  - UP: target > duty_cur.
  - DOWN: target < duty_cur.
  - State is registered; next state is computed from the compare of next-cycle target and duty_cur, evaluated every cycle.
  - A target change mid-ramp redirects immediately: e.g. UP -> DOWN with no return through HOLD.
- Ramp step on tick with enable=1:
  - UP: duty_cur += min(STEP, target - duty_cur).
  - DOWN: duty_cur -= min(STEP, duty_cur - target).
  - HOLD: no change.
  - Arithmetic uses 9-bit intermediates; duty_cur never overshoots target and never wraps below 0 or above 255.
- at_target = (state == HOLD), registered.
- PWM:
  - pwm_cnt is an 8-bit free-running counter, running while enable=1.
  - duty_shadow <= duty_cur only on the cycle pwm_cnt == 255, so duty changes land only at period boundaries (glitch-free).
  - pwm_out (registered) = enable & (pwm_cnt < duty_shadow).
  - duty 0 gives a constant low; duty 255 gives 255 high / 1 low per 256-cycle period.
- enable low:
  - pwm_out = 0 on the next cycle.
  - pwm_cnt = 0 and prescaler = 0; duty_cur and state are frozen.
  - target keeps tracking control_value.
- Re-enable:
  - Ramp resumes from the frozen duty_cur.
  - The first PWM period starts at pwm_cnt=0 with the existing duty_shadow.
- Simultaneous events:
  - tick and a target change on the same cycle: the step uses the pre-change state and target.
  - pwm_cnt==255 and a duty_cur update on the same cycle: duty_shadow takes the old duty_cur.
- Reset mid-ramp: every register returns to its reset value immediately, regardless of clock.

Test Plan:
- Reset then control_value=0, enable=1 for 2000 cycles -> pwm_out stays 0, duty_cur=0, at_target=1.
- RAMP_DIV=4, STEP=1, control_value 0->10 -> duty_cur increments by 1 every 4 cycles, reaches 10 about 40 cycles after capture, at_target rises then; measured PWM high time settles at 10 of 256.
- RAMP_DIV=4, STEP=16, duty_cur=250, control_value=255 -> one step to 255 (no overshoot); control_value=0 from 255 -> steps 239, 223, ..., 15, then 0.
- Mid-ramp reversal: ramping up 0->100, at duty_cur=40 set control_value=20 -> next tick gives 39, continues down to 20 without entering HOLD in between.
- enable dropped at duty_cur=50 for 100 cycles while control_value=200 -> pwm_out 0 next cycle, duty_cur holds 50; after re-enable, ramp resumes from 50 toward 200.
- Assert rst during an UP ramp at duty_cur=77 -> pwm_out, duty_cur and counters read 0 and at_target=1 before the next clk edge.
